// File: rtl/wb_cpu_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_cpu_master
// Brief    : Wishbone classic single-transfer master for the CPU data port,
//            with a bus timeout that returns an error word.
// Revision : 1.0 - initial release
// ============================================================================
module wb_cpu_master #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic [3:0]    r_sel;
    logic          r_we;
    logic          r_cyc;
    logic          r_done;
    logic          r_err;
    logic          w_accept;
    logic          w_ack_hit;
    logic          w_timeout;

    assign w_accept  = (r_state == S_IDLE) && req_i;
    assign w_ack_hit = (r_state == S_BUS) && wb_ack_i;
    // Ack wins over a timeout landing on the same edge.
    assign w_timeout = (r_state == S_BUS) && !wb_ack_i && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUS;
            S_BUS:   if (w_ack_hit || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_adr <= addr_i;
                r_dat <= wdata_i;
                r_sel <= be_i;
                r_we  <= we_i;
                r_cyc <= 1'b1;
                r_cnt <= '0;
            end else if (w_ack_hit) begin
                r_cyc  <= 1'b0;
                r_done <= 1'b1;
                if (!r_we) begin
                    r_rdata <= wb_dat_i;
                end
            end else if (w_timeout) begin
                r_cyc   <= 1'b0;
                r_rdata <= ERR_DATA;
                r_err   <= 1'b1;
                r_done  <= 1'b1;
            end else if (r_state == S_BUS) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Reset term keeps the core released while the bus is being torn down.
    assign stall_o  = req_i && (r_state != S_DONE) && !rst_i;
    assign rdata_o  = r_rdata;
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_wb_cpu_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_cpu_master
// Brief    : Directed self-checking bench for wb_cpu_master with a small
//            gpio-style Wishbone slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cpu_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    wire         wb_ack_i;

    // Slave modes: 0 = one-cycle ack, 1 = absent, 2 = ack held 2 cycles,
    // 3 = ack arrives on the last BUS cycle before timeout.
    int          slv_mode;
    logic        s_ack;
    logic        s_ack_d;
    logic        tb_ack;
    logic [31:0] slv_rdata;
    logic [31:0] gpio_out;
    int          bcnt;
    int          done_cnt = 0;
    int          vec_cnt  = 0;
    int          err_cnt  = 0;

    always #5 clk_i = ~clk_i;

    assign wb_ack_i = s_ack | tb_ack;
    assign wb_dat_i = slv_rdata;

    wb_cpu_master #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .be_i     (be_i),
        .rdata_o  (rdata_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i)
    );

    always @(posedge clk_i) begin
        if (rst_i) begin
            s_ack   <= 1'b0;
            s_ack_d <= 1'b0;
            bcnt    <= 0;
        end else begin
            s_ack_d <= s_ack;
            bcnt    <= wb_cyc_o ? bcnt + 1 : 0;
            case (slv_mode)
                0:       s_ack <= wb_cyc_o & wb_stb_o & ~s_ack;
                2:       s_ack <= (wb_cyc_o & wb_stb_o & ~s_ack) | (s_ack & ~s_ack_d);
                3:       s_ack <= wb_cyc_o & (bcnt == 14);
                default: s_ack <= 1'b0;
            endcase
            if (wb_cyc_o && wb_stb_o && wb_we_o && s_ack) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_sel_o[b]) gpio_out[8*b +: 8] <= wb_dat_o[8*b +: 8];
                end
            end
        end
    end

    always @(posedge clk_i) begin
        if (done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits (bounded) for done_o, sampling on negedges.
    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit keep_req,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int stall_n, output int cyc_n);
        bit got;
        got = 0; rd = '0; er = 1'b0; lat = 0; stall_n = 0; cyc_n = 0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; be_i = be;
        #1;
        if (stall_o) stall_n++;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            lat++;
            if (stall_o) stall_n++;
            if (wb_cyc_o) cyc_n++;
            if (done_o) begin
                rd = rdata_o; er = err_o; got = 1;
            end
        end
        chk("xfer_done_seen", {31'd0, got}, 32'd1);
        if (!keep_req) req_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, stn, cyn, d0;
    logic [31:0] rsave;

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        tb_ack = 1'b0; slv_mode = 0; slv_rdata = '0; gpio_out = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_cyc",   {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb",   {31'd0, wb_stb_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o},   32'd0);
        chk("rst_rdata", rdata_o,           32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Store to gpio
        d0 = done_cnt;
        xfer(1'b1, 32'h400, 32'h0000A5A5, 4'hF, 1'b0, rd, er, lat, stn, cyn);
        chk("st_latency", lat, 3);
        chk("st_cyc_cycles", cyn, 2);
        chk("st_err", {31'd0, er}, 32'd0);
        @(negedge clk_i);
        chk("st_gpio", gpio_out, 32'h0000A5A5);
        chk("st_done_count", done_cnt - d0, 1);

        // Load from gpio
        slv_rdata = 32'h00001234;
        xfer(1'b0, 32'h400, 32'h0, 4'hF, 1'b0, rd, er, lat, stn, cyn);
        chk("ld_rdata", rd, 32'h00001234);
        chk("ld_err", {31'd0, er}, 32'd0);
        chk("ld_stall_cycles", stn, 3);
        @(negedge clk_i);

        // Missing slave -> timeout
        slv_mode = 1;
        xfer(1'b0, 32'hF000, 32'h0, 4'hF, 1'b0, rd, er, lat, stn, cyn);
        chk("to_rdata", rd, 32'hDEADBEEF);
        chk("to_err", {31'd0, er}, 32'd1);
        chk("to_latency", lat, 17);
        chk("to_cyc_cycles", cyn, 16);
        @(negedge clk_i);

        // Ack on the very edge the timeout would fire: not an error
        slv_mode = 3; slv_rdata = 32'h55AA55AA;
        xfer(1'b0, 32'h404, 32'h0, 4'hF, 1'b0, rd, er, lat, stn, cyn);
        chk("edge_rdata", rd, 32'h55AA55AA);
        chk("edge_err", {31'd0, er}, 32'd0);
        chk("edge_latency", lat, 17);
        @(negedge clk_i);

        // Held ack, back-to-back requests
        slv_mode = 2; slv_rdata = 32'h0BADF00D; d0 = done_cnt;
        xfer(1'b0, 32'h400, 32'h0, 4'hF, 1'b1, rd, er, lat, stn, cyn);
        chk("b2b_ld_rdata", rd, 32'h0BADF00D);
        xfer(1'b1, 32'h400, 32'hFFFFFFC3, 4'h1, 1'b0, rd, er, lat, stn, cyn);
        chk("b2b_st_latency", lat, 3);
        chk("b2b_st_err", {31'd0, er}, 32'd0);
        repeat (3) @(negedge clk_i);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_gpio_sel", gpio_out, 32'h0000A5C3);
        chk("b2b_rdata_hold", rdata_o, 32'h0BADF00D);

        // Async reset in the 2nd BUS cycle
        slv_mode = 1; d0 = done_cnt;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h800; be_i = 4'hF;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rb_adr", wb_adr_o, 32'h800);
        chk("rb_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("rb_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rb_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rb_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0; rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rb_no_done", done_cnt - d0, 0);
        slv_mode = 0;
        xfer(1'b1, 32'h400, 32'h00000077, 4'hF, 1'b0, rd, er, lat, stn, cyn);
        chk("rb_after_latency", lat, 3);
        @(negedge clk_i);
        chk("rb_after_gpio", gpio_out, 32'h00000077);

        // Stray ack while idle
        d0 = done_cnt; rsave = rdata_o;
        @(negedge clk_i);
        tb_ack = 1'b1;
        @(negedge clk_i);
        tb_ack = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("idle_ack_done", done_cnt - d0, 0);
        chk("idle_ack_rdata", rdata_o, rsave);
        chk("idle_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("idle_ack_stall", {31'd0, stall_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
